// File: rtl/poets_system_mem_copy_master_if.sv
// Command, status and Avalon-MM signal bundle for the memory copy master.
// The master modport is the copy engine; slave is its environment.
interface poets_system_mem_copy_master_if #(
  parameter int ADDR_W = 14
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W:0]   cmd_len;
  logic [31:0]       cmd_pattern;
  logic              done;
  logic              err;
  logic              busy;
  logic [ADDR_W:0]   words_done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_clken;
  logic [31:0]       avm_readdata;

  modport master (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_src,
    input  cmd_dst,
    input  cmd_len,
    input  cmd_pattern,
    input  avm_readdata,
    output cmd_ready,
    output done,
    output err,
    output busy,
    output words_done,
    output avm_address,
    output avm_chipselect,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    output avm_clken
  );

  modport slave (
    output cmd_valid,
    output cmd_op,
    output cmd_src,
    output cmd_dst,
    output cmd_len,
    output cmd_pattern,
    output avm_readdata,
    input  cmd_ready,
    input  done,
    input  err,
    input  busy,
    input  words_done,
    input  avm_address,
    input  avm_chipselect,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    input  avm_clken
  );
endinterface

// File: rtl/poets_system_mem_copy_master.sv
// Avalon-MM block FILL / COPY master for a fixed-latency
// single-port memory without waitrequest.
module poets_system_mem_copy_master #(
  parameter int ADDR_W       = 14,
  parameter int DEPTH        = 12800,
  parameter int READ_LATENCY = 1
) (
  input logic clk,
  input logic reset_n,
  poets_system_mem_copy_master_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int WC_W =
    (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(READ_LATENCY - 1);
  localparam logic [ADDR_W+1:0] LIMIT =
    (ADDR_W+2)'(DEPTH);

  logic [2:0]        state;
  logic              op;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [31:0]       data;
  logic              err_q;
  logic [WC_W-1:0]   wcnt;

  logic [ADDR_W+1:0] dst_end;
  logic [ADDR_W+1:0] src_end;
  logic              range_bad;
  logic              len_zero;
  logic [ADDR_W-1:0] addr;
  logic              run;

  // Range ends carry two extra bits so dst+len never wraps.
  always_comb begin
    dst_end   = {2'b00, bus.cmd_dst}
              + {1'b0, bus.cmd_len};
    src_end   = {2'b00, bus.cmd_src}
              + {1'b0, bus.cmd_len};
    range_bad = (dst_end > LIMIT)
              | (bus.cmd_op & (src_end > LIMIT));
    len_zero  = (bus.cmd_len == '0);
    cnt_inc   = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op    <= 1'b0;
      src   <= '0;
      dst   <= '0;
      len   <= '0;
      cnt   <= '0;
      data  <= '0;
      err_q <= 1'b0;
      wcnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op    <= bus.cmd_op;
            src   <= bus.cmd_src;
            dst   <= bus.cmd_dst;
            len   <= bus.cmd_len;
            data  <= bus.cmd_pattern;
            cnt   <= '0;
            wcnt  <= '0;
            err_q <= range_bad;
            if (range_bad || len_zero)
              state <= S_DONE;
            else if (bus.cmd_op)
              state <= S_RD;
            else
              state <= S_WR;
          end
        end
        S_RD: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WC_LAST) begin
            data  <= bus.avm_readdata;
            state <= S_WR;
          end else begin
            wcnt <= wcnt + WC_W'(1);
          end
        end
        S_WR: begin
          cnt <= cnt_inc;
          if (cnt_inc == len)
            state <= S_DONE;
          else if (op)
            state <= S_RD;
          else
            state <= S_WR;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    addr = '0;
    if (state == S_RD)
      addr = src + cnt[ADDR_W-1:0];
    else if (state == S_WR)
      addr = dst + cnt[ADDR_W-1:0];
  end

  // Outputs are forced quiet while reset_n is low.
  assign run = reset_n;

  assign bus.cmd_ready = run & (state == S_IDLE);
  assign bus.done      = run & (state == S_DONE);
  assign bus.err       = run & (state == S_DONE)
                       & err_q;
  assign bus.busy      = run & ((state == S_RD)
                       | (state == S_WAIT)
                       | (state == S_WR));
  assign bus.words_done = run ? cnt : '0;

  assign bus.avm_clken      = reset_n;
  assign bus.avm_chipselect = run & ((state == S_RD)
                            | (state == S_WR));
  assign bus.avm_write      = run & (state == S_WR);
  assign bus.avm_address    = run ? addr : '0;
  assign bus.avm_byteenable =
    (run & (state == S_WR)) ? 4'hF : 4'h0;
  assign bus.avm_writedata  =
    (run & (state == S_WR)) ? data : 32'h0;

endmodule

// File: tb/tb_poets_system_mem_copy_master.sv
// Scoreboard bench for the memory copy master: a memory model,
// a reference image and queued expected writes / completions.
module tb_poets_system_mem_copy_master;

  localparam int AW    = 14;
  localparam int DEPTH = 12800;
  localparam int RL    = 1;

  typedef struct {
    int          a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int cyc;
    bit err;
    int wd;
    int acc;
    int base;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  poets_system_mem_copy_master_if #(.ADDR_W(AW)) bus();

  poets_system_mem_copy_master #(
    .ADDR_W(AW),
    .DEPTH(DEPTH),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int acc_cnt = 0;
  int wr_seen = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] rdata_q = '0;
  wr_t  bd_q [$];
  wr_t  bd_e;
  wr_t  wq [$];
  rsp_t rq [$];
  wr_t  mw;
  rsp_t mr;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.avm_readdata = rdata_q;

  always @(posedge clk) begin
    while (bd_q.size() > 0) begin
      bd_e = bd_q.pop_front();
      mem[bd_e.a] <= bd_e.d;
    end
    if (bus.avm_clken && bus.avm_chipselect) begin
      acc_cnt <= acc_cnt + 1;
      if (int'(bus.avm_address) < DEPTH) begin
        if (bus.avm_write)
          mem[bus.avm_address] <= bus.avm_writedata;
        else
          rdata_q <= mem[bus.avm_address];
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.avm_chipselect && bus.avm_write) begin
        wr_seen <= wr_seen + 1;
        chk("write_queued", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          mw = wq.pop_front();
          chk("write_addr", 64'(bus.avm_address), 64'(mw.a));
          chk("write_data",
              64'({bus.avm_byteenable, bus.avm_writedata}),
              64'({4'hF, mw.d}));
        end
      end else begin
        chk("quiet_wdata",
            64'({bus.avm_byteenable, bus.avm_writedata}),
            64'd0);
      end
      if (bus.done) begin
        chk("done_queued", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) begin
          mr = rq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mr.cyc));
          chk("done_err", 64'(bus.err), 64'(mr.err));
          chk("words_done", 64'(bus.words_done), 64'(mr.wd));
          chk("accesses", 64'(acc_cnt - mr.base), 64'(mr.acc));
        end
      end
    end
  end

  task automatic preload(input int a, input logic [31:0] v);
    ref_mem[a] = v;
    bd_q.push_back('{a: a, d: v});
  endtask

  task automatic check_word(input string nm, input int a,
                            input logic [31:0] exp);
    chk(nm, 64'(mem[a]), 64'(exp));
  endtask

  task automatic ctl_vec(output logic [63:0] v);
    v = 64'({bus.avm_chipselect, bus.avm_write,
             bus.avm_clken, bus.avm_byteenable,
             bus.avm_address, bus.done, bus.err,
             bus.busy, bus.cmd_ready, bus.words_done});
  endtask

  task automatic check_reset_zero(input string nm);
    logic [63:0] v;
    ctl_vec(v);
    chk(nm, v, 64'd0);
    chk("reset_wdata", 64'(bus.avm_writedata), 64'd0);
  endtask

  task automatic check_idle(input string nm);
    logic [63:0] v;
    logic [63:0] e;
    ctl_vec(v);
    e = 64'({1'b0, 1'b0, 1'b1, 4'h0, 14'h0,
             1'b0, 1'b0, 1'b0, 1'b1, 15'h0});
    chk(nm, v, e);
  endtask

  task automatic issue(input bit op, input int src,
                       input int dst, input int len,
                       input logic [31:0] pat,
                       input int partial,
                       output int acc_t);
    int n;
    bit e;
    int nw;
    int lat;
    logic [31:0] d;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_src     = AW'(src);
    bus.cmd_dst     = AW'(dst);
    bus.cmd_len     = (AW+1)'(len);
    bus.cmd_pattern = pat;
    n = 0;
    while (!bus.cmd_ready && n < 5000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("accept", 64'(bus.cmd_ready), 64'd1);
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      acc_t = -1;
      return;
    end
    acc_t = cyc;
    e = (dst + len > DEPTH) || (op && (src + len > DEPTH));
    nw = e ? 0 : len;
    if (partial >= 0) nw = partial;
    for (int k = 0; k < nw; k++) begin
      d = op ? ref_mem[src + k] : pat;
      ref_mem[dst + k] = d;
      wq.push_back('{a: dst + k, d: d});
    end
    if (e || len == 0) lat = 1;
    else if (op) lat = (RL + 2) * len + 1;
    else lat = len + 1;
    if (partial < 0)
      rq.push_back('{cyc: acc_t + lat, err: e,
                     wd: e ? 0 : len,
                     acc: e ? 0 : (op ? 2 * len : len),
                     base: acc_cnt});
    @(posedge clk); #2;
  endtask

  task automatic release_cmd();
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 1'($urandom);
    bus.cmd_src     = AW'($urandom);
    bus.cmd_dst     = AW'($urandom);
    bus.cmd_len     = (AW+1)'($urandom);
    bus.cmd_pattern = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 5000 &&
           !(rq.size() == 0 && wq.size() == 0 &&
             bus.cmd_ready)) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain",
        64'({bus.cmd_ready, 16'(rq.size()), 16'(wq.size())}),
        64'({1'b1, 16'd0, 16'd0}));
    rq.delete();
    wq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int a1;
    int base;
    int n;
    int op;
    int src;
    int dst;
    int len;
    int r;
    bit held;
    logic [31:0] v;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 1'b0;
    bus.cmd_src     = '0;
    bus.cmd_dst     = '0;
    bus.cmd_len     = '0;
    bus.cmd_pattern = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      preload(i, v);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_zero("reset_outputs");
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("idle_after_reset");
    @(posedge clk); #2;

    issue(1'b0, 0, 100, 4, 32'hDEADBEEF, -1, a0);
    release_cmd();
    drain();
    for (int k = 0; k < 4; k++)
      check_word("fill_readback", 100 + k, 32'hDEADBEEF);

    for (int k = 0; k < 8; k++) preload(k, 32'h1000 + k);
    @(posedge clk); #2;
    issue(1'b1, 0, 200, 8, 32'h0, -1, a0);
    release_cmd();
    drain();
    for (int k = 0; k < 8; k++)
      check_word("copy_readback", 200 + k, 32'h1000 + k);

    issue(1'b1, 12795, 0, 6, 32'h0, -1, a0);
    release_cmd();
    drain();
    issue(1'b0, 0, 16383, 32767, 32'h1, -1, a0);
    release_cmd();
    drain();
    issue(1'b0, 0, 12799, 1, 32'hCAFEF00D, -1, a0);
    release_cmd();
    drain();
    check_word("last_word", 12799, 32'hCAFEF00D);

    issue(1'b0, 0, 50, 0, 32'h55, -1, a0);
    issue(1'b1, 7, 60, 0, 32'h0, -1, a1);
    chk("held_len0_accept", 64'(a1 - a0), 64'd2);
    issue(1'b0, 0, 500, 3, 32'h600DF00D, -1, a0);
    issue(1'b1, 500, 600, 3, 32'h0, -1, a1);
    chk("held_busy_accept", 64'(a1 - a0), 64'd5);
    release_cmd();
    drain();
    for (int k = 0; k < 3; k++)
      check_word("chain_readback", 600 + k, 32'h600DF00D);

    for (int k = 0; k < 5; k++) preload(k, 32'hA0 + k);
    @(posedge clk); #2;
    issue(1'b1, 0, 1, 4, 32'h0, -1, a0);
    release_cmd();
    drain();
    for (int k = 1; k < 5; k++)
      check_word("overlap_readback", k, 32'hA0);

    for (int k = 0; k < 8; k++) preload(k, 32'h2000 + k);
    for (int k = 0; k < 8; k++) preload(300 + k, 32'h0);
    @(posedge clk); #2;
    base = wr_seen;
    issue(1'b1, 0, 300, 8, 32'h0, 3, a0);
    release_cmd();
    n = 0;
    while (wr_seen < base + 3 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("writes_before_reset", 64'(wr_seen - base), 64'd3);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_zero("reset_mid_copy");
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("idle_after_mid_reset");
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++)
      check_word("partial_written", 300 + k, 32'h2000 + k);
    for (int k = 3; k < 8; k++)
      check_word("partial_untouched", 300 + k, 32'h0);
    issue(1'b0, 0, 310, 2, 32'h0BADC0DE, -1, a0);
    release_cmd();
    drain();
    check_word("post_reset_fill", 310, 32'h0BADC0DE);

    held = 1'b0;
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r == 0) len = int'($urandom_range(DEPTH + 1, 32767));
      else if (r == 1) len = 0;
      else len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 4) == 0)
        dst = DEPTH - int'($urandom_range(0, 12));
      else
        dst = int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 4) == 0)
        src = DEPTH - int'($urandom_range(0, 12));
      else
        src = int'($urandom_range(0, DEPTH - 1));
      issue(op[0], src, dst, len, $urandom, -1, a0);
      held = $urandom_range(0, 1) == 1;
      if (!held) begin
        release_cmd();
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #2;
        end
      end
    end
    release_cmd();
    drain();

    n = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) n++;
    chk("mem_image", 64'(n), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
